// File: rtl/dmem_arb_pkg.sv
// Shared types and sizing helpers for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    P_CPU = 1'b0,
    P_DMA = 1'b1
  } pri_e;

  typedef enum logic [1:0] {
    T_NONE = 2'd0,
    T_CPU  = 2'd1,
    T_DMA  = 2'd2
  } rd_tag_e;

  // Width able to hold 0..limit, so a counter can never wrap before it is cleared.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_limit_counter.sv
// Saturating up-counter with synchronous clear and a terminal-count flag at LIMIT-1.
module arb_limit_counter
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int W = cnt_width(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != W'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign tc = (cnt_q == W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between the CPU MEM stage and a DMA port,
// with a starvation guard for DMA and a burst cap that hands priority back to the CPU.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int BURST_MAX    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  pri_e              pri_q, pri_d;
  rd_tag_e           rd_tag_q, rd_tag_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  logic cpu_win, dma_win, contested;
  logic win_inc, win_clr, win_tc;
  logic beat_inc, beat_clr, beat_tc;

  // Grants are suppressed while reset is held so no access slips through.
  always_comb begin
    contested = cpu_req & dma_req;
    cpu_win   = reset & cpu_req & (~dma_req | (pri_q == P_CPU));
    dma_win   = reset & dma_req & (~cpu_req | (pri_q == P_DMA));
  end

  assign cpu_stall = cpu_req & ~cpu_win;
  assign dma_gnt   = dma_win;

  always_comb begin
    mem_en    = cpu_win | dma_win;
    mem_we    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (cpu_win) begin
      mem_we = cpu_we;
    end else if (dma_win) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  always_comb begin
    pri_d    = pri_q;
    win_inc  = 1'b0;
    win_clr  = 1'b0;
    beat_inc = 1'b0;
    beat_clr = 1'b0;
    if (pri_q == P_CPU) begin
      if (contested) begin
        win_inc = 1'b1;
        if (win_tc) begin
          pri_d    = P_DMA;
          win_clr  = 1'b1;
          beat_clr = 1'b1;
        end
      end else if (!dma_req) begin
        win_clr = 1'b1;
      end
    end else begin
      win_clr  = 1'b1;
      beat_inc = dma_gnt;
      if (!dma_req || (dma_gnt && beat_tc)) begin
        pri_d    = P_CPU;
        beat_clr = 1'b1;
      end
    end
  end

  arb_limit_counter #(.LIMIT(STARVE_LIMIT)) u_win_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (win_clr),
    .inc   (win_inc),
    .tc    (win_tc)
  );

  arb_limit_counter #(.LIMIT(BURST_MAX)) u_beat_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (beat_clr),
    .inc   (beat_inc),
    .tc    (beat_tc)
  );

  // The tag remembers who owns the read now in flight inside the RAM.
  always_comb begin
    rd_tag_d = T_NONE;
    if (cpu_win && !cpu_we) begin
      rd_tag_d = T_CPU;
    end else if (dma_win && !dma_we) begin
      rd_tag_d = T_DMA;
    end
    cpu_rdata_d = (rd_tag_q == T_CPU) ? mem_rdata : cpu_rdata_q;
    dma_rdata_d = (rd_tag_q == T_DMA) ? mem_rdata : dma_rdata_q;
  end

  assign cpu_rvalid = reset & (rd_tag_q == T_CPU);
  assign dma_rvalid = reset & (rd_tag_q == T_DMA);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign dma_rdata  = dma_rvalid ? mem_rdata : dma_rdata_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pri_q       <= P_CPU;
      rd_tag_q    <= T_NONE;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      pri_q       <= pri_d;
      rd_tag_q    <= rd_tag_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed table, multi-cycle corner sequences and random traffic
// checked against a rule-level reference model with its own copy of memory.
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SL = 4;
  localparam int BM = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, mem_wdata, mem_rdata;
  logic          cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, mem_en, mem_we;
  logic [DW-1:0] cpu_rdata, dma_rdata;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .BURST_MAX(BM)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Environment RAM: single port, registered read.
  logic [DW-1:0] ram [256];
  logic          ram_clr;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model state: priority owner (0=CPU,1=DMA), counts, pending read owner (0/1/2).
  int            m_pri, m_win, m_beat, m_pend;
  logic [DW-1:0] m_pend_data, m_crd, m_drd;
  logic [DW-1:0] m_mem [256];

  int   n_vec = 0, n_bad = 0;
  logic s_stall, s_gnt, s_crv, s_drv;
  logic [DW-1:0] s_crd, s_drd;
  logic last_gnt, last_stall;
  int   stall_run, max_stall, dwait, max_dwait;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic creq, input logic cwe, input logic [AW-1:0] caddr,
                       input logic [DW-1:0] cwd, input logic dreq, input logic dwe,
                       input logic [AW-1:0] daddr, input logic [DW-1:0] dwd);
    logic cw, dw, e_crv, e_drv;
    logic [DW-1:0] e_crd, e_drd;
    logic [40:0] e_bus;
    reset = rst; cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd;
    @(negedge clk);
    cw    = rst & creq & (!dreq | (m_pri == 0));
    dw    = rst & dreq & (!creq | (m_pri == 1));
    e_bus = cw ? {cwe, caddr, cwd} : {dwe, daddr, dwd};
    e_crv = rst & (m_pend == 1);
    e_drv = rst & (m_pend == 2);
    e_crd = e_crv ? m_pend_data : m_crd;
    e_drd = e_drv ? m_pend_data : m_drd;
    s_stall = cpu_stall; s_gnt = dma_gnt; s_crv = cpu_rvalid; s_drv = dma_rvalid;
    s_crd = cpu_rdata; s_drd = dma_rdata;
    chk("cpu_stall", 64'(cpu_stall), 64'(creq & !cw));
    chk("dma_gnt", 64'(dma_gnt), 64'(dw));
    chk("mem_en", 64'(mem_en), 64'(cw | dw));
    if (cw | dw) chk("mem_bus", 64'({mem_we, mem_addr, mem_wdata}), 64'(e_bus));
    chk("cpu_rvalid", 64'(cpu_rvalid), 64'(e_crv));
    chk("cpu_rdata", 64'(cpu_rdata), 64'(e_crd));
    chk("dma_rvalid", 64'(dma_rvalid), 64'(e_drv));
    chk("dma_rdata", 64'(dma_rdata), 64'(e_drd));
    stall_run = (rst & creq & !cw) ? stall_run + 1 : 0;
    dwait     = (rst & dreq & !dw) ? dwait + 1 : 0;
    if (stall_run > max_stall) max_stall = stall_run;
    if (dwait > max_dwait) max_dwait = dwait;
    last_gnt = dw; last_stall = creq & !cw;
    @(posedge clk);
    if (!rst) begin
      m_pri = 0; m_win = 0; m_beat = 0; m_pend = 0; m_crd = '0; m_drd = '0;
    end else begin
      if (m_pend == 1) m_crd = m_pend_data;
      if (m_pend == 2) m_drd = m_pend_data;
      m_pend = 0;
      if (cw) begin
        if (cwe) m_mem[caddr] = cwd; else begin m_pend = 1; m_pend_data = m_mem[caddr]; end
      end else if (dw) begin
        if (dwe) m_mem[daddr] = dwd; else begin m_pend = 2; m_pend_data = m_mem[daddr]; end
      end
      if (m_pri == 0) begin
        if (creq && dreq) begin
          m_win++;
          if (m_win == SL) begin m_pri = 1; m_win = 0; m_beat = 0; end
        end else if (!dreq) m_win = 0;
      end else begin
        m_win = 0;
        if (!dreq) begin m_pri = 0; m_beat = 0; end
        else begin
          m_beat++;
          if (m_beat == BM) begin m_pri = 0; m_beat = 0; end
        end
      end
    end
    #1;
  endtask

  typedef struct {
    logic rst; logic creq; logic cwe; logic [AW-1:0] caddr; logic [DW-1:0] cwd;
    logic dreq; logic dwe; logic [AW-1:0] daddr; logic [DW-1:0] dwd;
    logic e_stall; logic e_gnt; logic e_crv; logic [DW-1:0] e_crd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          c_req, c_we, d_req, d_we, r_rst;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wd, d_wd;
    int            g [40];
    int            beats, ncyc, sum;

    tbl[0] = '{1'b1, 1'b1, 1'b1, 8'd5, 32'hDEADBEEF, 1'b0, 1'b0, 8'd0, 32'd0,          1'b0, 1'b0, 1'b0, 32'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 8'd5, 32'd0,        1'b0, 1'b0, 8'd0, 32'd0,          1'b0, 1'b0, 1'b0, 32'd0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 8'd0, 32'd0,        1'b0, 1'b0, 8'd0, 32'd0,          1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 8'd5, 32'd0,        1'b1, 1'b1, 8'd9, 32'h12345678,   1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 8'd5, 32'd0,        1'b1, 1'b1, 8'd9, 32'h12345678,   1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 8'd5, 32'd0,        1'b1, 1'b1, 8'd9, 32'h12345678,   1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 8'd5, 32'd0,        1'b1, 1'b1, 8'd9, 32'h12345678,   1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 8'd9, 32'd0,        1'b1, 1'b1, 8'd9, 32'h12345678,   1'b1, 1'b1, 1'b1, 32'hDEADBEEF};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 8'd9, 32'd0,        1'b0, 1'b0, 8'd0, 32'd0,          1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 8'd0, 32'd0,        1'b0, 1'b0, 8'd0, 32'd0,          1'b0, 1'b0, 1'b1, 32'h12345678};

    m_pri = 0; m_win = 0; m_beat = 0; m_pend = 0; m_pend_data = '0; m_crd = '0; m_drd = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    stall_run = 0; max_stall = 0; dwait = 0; max_dwait = 0;
    last_gnt = 1'b0; last_stall = 1'b0;
    ram_clr = 1'b1;

    // Reset held for two cycles under random requests.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), $urandom,
            1'($urandom), 1'($urandom), 8'($urandom), $urandom);
      ram_clr = 1'b0;
      chk($sformatf("rst%0d_gnt", i), 64'(s_gnt), 64'(0));
      chk($sformatf("rst%0d_rv", i), 64'({s_crv, s_drv}), 64'(0));
    end

    // Directed table: CPU write/read, starvation switch, DMA-write then CPU-read ordering.
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].rst, tbl[i].creq, tbl[i].cwe, tbl[i].caddr, tbl[i].cwd,
            tbl[i].dreq, tbl[i].dwe, tbl[i].daddr, tbl[i].dwd);
      chk($sformatf("v%0d_stall", i), 64'(s_stall), 64'(tbl[i].e_stall));
      chk($sformatf("v%0d_gnt", i), 64'(s_gnt), 64'(tbl[i].e_gnt));
      chk($sformatf("v%0d_crv", i), 64'(s_crv), 64'(tbl[i].e_crv));
      chk($sformatf("v%0d_crd", i), 64'(s_crd), 64'(tbl[i].e_crd));
    end

    // Burst cap: both requesting, DMA streams 12 writes.
    beats = 0; ncyc = 0;
    for (int k = 0; k < 40; k++) g[k] = 0;
    for (int k = 0; k < 40 && beats < 12; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 8'd20, 32'd0, 1'b1, 1'b1, 8'(40 + beats), 32'hA000_0000 + 32'(beats));
      g[k] = int'(s_gnt);
      if (last_gnt) beats++;
      ncyc++;
    end
    chk("burst_beats", 64'(beats), 64'(12));
    chk("burst_cycles", 64'(ncyc), 64'(20));
    sum = g[0] + g[1] + g[2] + g[3];
    chk("burst_lead", 64'(sum), 64'(0));
    sum = 0;
    for (int k = 4; k < 12; k++) sum += g[k];
    chk("burst_window", 64'(sum), 64'(8));
    chk("burst_release", 64'(g[12]), 64'(0));
    cycle(1'b1, 1'b1, 1'b0, 8'd47, 32'd0, 1'b0, 1'b0, 8'd0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 8'd0, 32'd0);
    chk("burst_data", 64'(s_crd), 64'(32'hA000_0007));

    // Reset right after a granted DMA read discards the result.
    cycle(1'b1, 1'b0, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 8'd9, 32'd0);
    chk("rmr_gnt", 64'(s_gnt), 64'(1));
    cycle(1'b0, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 8'd0, 32'd0);
    chk("rmr_rv_in_reset", 64'(s_drv), 64'(0));
    cycle(1'b1, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 8'd0, 32'd0);
    chk("rmr_rv_after", 64'(s_drv), 64'(0));
    chk("rmr_rdata", 64'(s_drd), 64'(0));

    // Random traffic; both masters hold their request until it is accepted.
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wd = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wd = '0;
    max_stall = 0; max_dwait = 0; stall_run = 0; dwait = 0;
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        c_req = ($urandom_range(0, 99) < 65); c_we = 1'($urandom);
        c_addr = 8'($urandom_range(0, 15)); c_wd = $urandom;
      end
      if (!d_req || last_gnt) begin
        d_req = ($urandom_range(0, 99) < 80); d_we = 1'($urandom);
        d_addr = 8'($urandom_range(0, 15)); d_wd = $urandom;
      end
      r_rst = ($urandom_range(0, 99) >= 2);
      cycle(r_rst, c_req, c_we, c_addr, c_wd, d_req, d_we, d_addr, d_wd);
    end
    chk("stall_bound", 64'(max_stall <= BM), 64'(1));
    chk("dma_wait_bound", 64'(max_dwait <= SL), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
